// File: rtl/mem_arbiter.sv
// Shared main-memory port sequencer: D-priority arbitration with an I anti-starvation
// guard, pipelined line-fill reads, single-word writes, fixed-latency return tracking.
module mem_arbiter #(
    parameter int BURST_LEN    = 8,
    parameter int MEM_LAT      = 4,
    parameter int D_STREAK_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_rvalid,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_rvalid,
    output logic        d_ack,
    output logic [15:0] rdata,
    output logic [2:0]  widx,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);
    localparam int            SW         = $clog2(D_STREAK_MAX + 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);
    localparam logic [2:0]    LAST_IDX   = 3'(BURST_LEN - 1);
    localparam logic [15:0]   LINE_MASK  = ~16'(2 * BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_WAIT, TURN} state_t;

    state_t        r_state, w_next;
    logic [2:0]    r_cnt;
    logic [15:0]   r_base, r_wdata;
    logic [SW-1:0] r_streak;
    logic          r_owner;

    // Return tracker: stage j holds the issue made j cycles ago.
    logic [MEM_LAT:1]      r_pv, r_pwr, r_plast, r_pown;
    logic [MEM_LAT:1][2:0] r_pidx;

    logic        r_i_rvalid, r_d_rvalid, r_i_ack, r_d_ack;
    logic [15:0] r_rdata;
    logic [2:0]  r_widx;

    logic w_grant_d, w_grant_i, w_accept, w_issue_rd, w_issue_wr, w_ack;

    assign w_grant_d = d_req & ~(i_req & (r_streak == STREAK_MAX));
    assign w_grant_i = i_req & ~w_grant_d;
    assign w_accept  = (r_state == IDLE) & (i_req | d_req);
    assign w_ack     = r_i_ack | r_d_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)      w_next = d_wr ? WR_WAIT : RD_ISSUE;
                else if (w_grant_i) w_next = RD_ISSUE;
            end
            RD_ISSUE: if (r_cnt == LAST_IDX) w_next = RD_DRAIN;
            RD_DRAIN: if (w_ack) w_next = TURN;
            WR_WAIT:  if (w_ack) w_next = TURN;
            TURN:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_issue_rd = (r_state == RD_ISSUE);
        w_issue_wr = (r_state == WR_WAIT) && (r_cnt == 3'd0);
        busy       = (r_state != IDLE);
        mem_en     = w_issue_rd | w_issue_wr;
        mem_wr     = w_issue_wr;
        mem_addr   = 16'h0;
        mem_wdata  = 16'h0;
        if (w_issue_rd) mem_addr = r_base + {12'b0, r_cnt, 1'b0};
        if (w_issue_wr) begin
            mem_addr  = r_base;
            mem_wdata = r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_base   <= '0;
            r_wdata  <= '0;
            r_streak <= '0;
            r_owner  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt    <= '0;
                    r_streak <= (i_req & w_grant_d) ? r_streak + SW'(1) : '0;
                    if (w_accept) begin
                        r_owner <= w_grant_d;
                        r_wdata <= d_wdata;
                        if (w_grant_d) r_base <= d_wr ? (d_addr & 16'hFFFE) : (d_addr & LINE_MASK);
                        else           r_base <= i_addr & LINE_MASK;
                    end
                end
                RD_ISSUE: r_cnt <= r_cnt + 3'd1;
                WR_WAIT:  r_cnt <= 3'd1;
                default:  r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pv    <= '0;
            r_pwr   <= '0;
            r_plast <= '0;
            r_pown  <= '0;
            r_pidx  <= '0;
        end else begin
            for (int j = MEM_LAT; j > 1; j--) begin
                r_pv[j]    <= r_pv[j-1];
                r_pwr[j]   <= r_pwr[j-1];
                r_plast[j] <= r_plast[j-1];
                r_pown[j]  <= r_pown[j-1];
                r_pidx[j]  <= r_pidx[j-1];
            end
            r_pv[1]    <= mem_en;
            r_pwr[1]   <= mem_wr;
            r_plast[1] <= w_issue_wr | (w_issue_rd & (r_cnt == LAST_IDX));
            r_pown[1]  <= r_owner;
            r_pidx[1]  <= r_cnt;
        end
    end

    // The tail stage lines up with mem_rdata being valid; capture it one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_rdata    <= '0;
            r_widx     <= '0;
        end else begin
            r_i_rvalid <= r_pv[MEM_LAT] & ~r_pwr[MEM_LAT] & ~r_pown[MEM_LAT];
            r_d_rvalid <= r_pv[MEM_LAT] & ~r_pwr[MEM_LAT] &  r_pown[MEM_LAT];
            r_i_ack    <= r_pv[MEM_LAT] & r_plast[MEM_LAT] & ~r_pown[MEM_LAT];
            r_d_ack    <= r_pv[MEM_LAT] & r_plast[MEM_LAT] &  r_pown[MEM_LAT];
            if (r_pv[MEM_LAT] & ~r_pwr[MEM_LAT]) begin
                r_rdata <= mem_rdata;
                r_widx  <= r_pidx[MEM_LAT];
            end else begin
                r_widx  <= '0;
            end
        end
    end

    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign i_ack    = r_i_ack;
    assign d_ack    = r_d_ack;
    assign rdata    = r_rdata;
    assign widx     = r_widx;
    assign owner    = r_owner;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-indexed expectation tables built from the transaction
// rules, compared every cycle, plus hand-computed literal checks per scenario.
module tb_mem_arbiter;
    localparam int BL = 8, ML = 4, DSM = 3, MAXC = 2048;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        i_rvalid, i_ack, d_rvalid, d_ack, mem_en, mem_wr, busy, owner;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic [2:0]  widx;

    mem_arbiter #(.BURST_LEN(BL), .MEM_LAT(ML), .D_STREAK_MAX(DSM)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_ack(i_ack),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_ack(d_ack),
        .rdata(rdata), .widx(widx),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    // Expected outputs per absolute cycle.
    bit          e_men[MAXC], e_mwr[MAXC], e_iv[MAXC], e_dv[MAXC], e_ia[MAXC], e_da[MAXC];
    bit          e_busy[MAXC], e_own[MAXC];
    logic [15:0] e_maddr[MAXC], e_mwd[MAXC], e_rdata[MAXC];
    logic [2:0]  e_widx[MAXC];
    bit          h_en[MAXC];
    logic [15:0] h_addr[MAXC];
    int          m_free = 0, m_streak = 0;
    bit          chk_en = 0;

    function automatic void clear_from(input int c);
        for (int t = c; t < MAXC; t++) begin
            e_men[t] = 0; e_mwr[t] = 0; e_iv[t] = 0; e_dv[t] = 0; e_ia[t] = 0; e_da[t] = 0;
            e_busy[t] = 0; e_own[t] = 0; e_maddr[t] = '0; e_mwd[t] = '0; e_rdata[t] = '0;
            e_widx[t] = '0;
        end
    endfunction

    // Lay out one whole transaction accepted at cycle c.
    function automatic void sched(input int c, input bit o, input bit wr,
                                  input logic [15:0] a, input logic [15:0] w);
        int ack;
        logic [15:0] base, wa;
        if (wr) begin
            e_men[c+1] = 1; e_mwr[c+1] = 1;
            e_maddr[c+1] = a & 16'hFFFE; e_mwd[c+1] = w;
            ack = c + 2 + ML;
        end else begin
            base = a & ~16'(2 * BL - 1);
            for (int k = 0; k < BL; k++) begin
                wa = base + 16'(2 * k);
                e_men[c+1+k] = 1; e_maddr[c+1+k] = wa;
                if (o) e_dv[c+2+k+ML] = 1; else e_iv[c+2+k+ML] = 1;
                e_widx[c+2+k+ML] = 3'(k);
                for (int u = c + 2 + k + ML; u < MAXC; u++) e_rdata[u] = memf(wa);
            end
            ack = c + BL + 1 + ML;
        end
        if (o) e_da[ack] = 1; else e_ia[ack] = 1;
        for (int u = c + 1; u <= ack + 1; u++) e_busy[u] = 1;
        for (int u = c + 1; u < MAXC; u++) e_own[u] = o;
        m_free = ack + 2;
    endfunction

    initial begin
        clear_from(0);
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("mem_en", 32'(mem_en), 32'(e_men[cyc]));
                chk("mem_wr", 32'(mem_wr), 32'(e_mwr[cyc]));
                chk("mem_addr", 32'(mem_addr), 32'(e_maddr[cyc]));
                chk("mem_wdata", 32'(mem_wdata), 32'(e_mwd[cyc]));
                chk("i_rvalid", 32'(i_rvalid), 32'(e_iv[cyc]));
                chk("d_rvalid", 32'(d_rvalid), 32'(e_dv[cyc]));
                chk("i_ack", 32'(i_ack), 32'(e_ia[cyc]));
                chk("d_ack", 32'(d_ack), 32'(e_da[cyc]));
                chk("rdata", 32'(rdata), 32'(e_rdata[cyc]));
                chk("widx", 32'(widx), 32'(e_widx[cyc]));
                chk("busy", 32'(busy), 32'(e_busy[cyc]));
                chk("owner", 32'(owner), 32'(e_own[cyc]));
            end
            h_en[cyc]   = (mem_en === 1'b1) && (mem_wr === 1'b0);
            h_addr[cyc] = mem_addr;
            if (!rst_n) begin
                clear_from(cyc + 1);
                m_streak = 0;
                m_free   = cyc + 1;
                chk_en   = 1;
            end else if (chk_en && cyc >= m_free) begin
                if (!i_req) m_streak = 0;
                if (d_req && !(i_req && m_streak == DSM)) begin
                    if (i_req) m_streak++;
                    sched(cyc, 1'b1, d_wr, d_addr, d_wdata);
                end else if (i_req) begin
                    m_streak = 0;
                    sched(cyc, 1'b0, 1'b0, i_addr, 16'h0);
                end
            end
        end
    end

    // Memory: data for a read issued at cycle t is presented during cycle t+ML.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (cyc >= ML && h_en[cyc-ML]) mem_rdata = memf(h_addr[cyc-ML]);
            else                           mem_rdata = 16'h0BAD;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    int        ng, nrv, c0;
    bit        prevb;
    bit  [7:0] gown;
    int        gcyc[8];
    logic [7:0] exp_order;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // I line fill from an unaligned address
        i_req = 1'b1; i_addr = 16'h1236;
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 14) i_req = 1'b0;
            #2;
            if (n == 1)  chk("t1_first_addr", 32'(mem_addr), 32'h1230);
            if (n == 8)  chk("t1_last_addr", 32'(mem_addr), 32'h123E);
            if (n == 6) begin
                chk("t1_first_rvalid", 32'(i_rvalid), 32'd1);
                chk("t1_first_rdata", 32'(rdata), 32'h486A);
            end
            if (n == 13) begin
                chk("t1_ack", 32'(i_ack), 32'd1);
                chk("t1_last_widx", 32'(widx), 32'd7);
            end
            if (n == 15) chk("t1_busy_low", 32'(busy), 32'd0);
        end

        // D word write
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h4001; d_wdata = 16'hBEEF;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 7) d_req = 1'b0;
            #2;
            if (n == 1) begin
                chk("t2_addr", 32'(mem_addr), 32'h4000);
                chk("t2_wr", 32'(mem_wr), 32'd1);
                chk("t2_wdata", 32'(mem_wdata), 32'hBEEF);
            end
            if (n == 6) begin
                chk("t2_ack", 32'(d_ack), 32'd1);
                chk("t2_no_rvalid", 32'(d_rvalid), 32'd0);
            end
        end

        // Both sides held continuously: streak guard forces every fourth grant to I
        tick();
        d_wr = 1'b0; d_addr = 16'h2014; i_addr = 16'h3002;
        i_req = 1'b1; d_req = 1'b1;
        ng = 0; prevb = 1'b0; gown = '0;
        for (int n = 0; n < 200 && ng < 8; n++) begin
            tick(); #2;
            if (busy === 1'b1 && !prevb) begin
                gown[ng] = owner;
                gcyc[ng] = cyc;
                ng++;
            end
            prevb = (busy === 1'b1);
        end
        chk("t3_grants", 32'(ng), 32'd8);
        exp_order = 8'b0111_0111;
        chk("t3_order", 32'(gown), 32'(exp_order));
        chk("t3_regrant_gap", 32'(gcyc[1] - gcyc[0]), 32'd15);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        repeat (20) tick();

        // Reset in the middle of an I burst
        i_req = 1'b1; i_addr = 16'h5678;
        for (int n = 1; n <= 7; n++) tick();
        rst_n = 1'b0; i_req = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_mem_en", 32'(mem_en), 32'd0);
        chk("t4_mem_addr", 32'(mem_addr), 32'd0);
        chk("t4_rdata", 32'(rdata), 32'd0);
        chk("t4_rvalid", 32'(i_rvalid), 32'd0);
        chk("t4_owner", 32'(owner), 32'd0);
        nrv = 0;
        for (int n = 0; n < 20; n++) begin
            tick(); #2;
            if (i_rvalid === 1'b1 || i_ack === 1'b1) nrv++;
        end
        chk("t4_no_returns", 32'(nrv), 32'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
